usr_burst_shifter: RTL

//   Parametrised multi-mode shift register with a burst sequencer. One command (mode + count)
//   is latched on a start strobe and executed as `count` single-bit steps, one per clock.

---
 rtl/usr_pkg.sv | 27 ++
 rtl/usr_step_unit.sv | 27 ++
 rtl/usr_burst_shifter.sv | 104 ++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared types for the burst shifter: command modes and sequencer states.
// Optional abort input is enabled with `define USR_ABORT_EN.
package usr_pkg;

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHR  = 3'b001,
        M_SHL  = 3'b010,
        M_LOAD = 3'b011,
        M_ROR  = 3'b100,
        M_ROL  = 3'b101,
        M_ASR  = 3'b110,
        M_RSVD = 3'b111
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Commands that complete without entering RUN.
    function automatic logic is_trivial(input mode_t m);
        return (m == M_HOLD) || (m == M_RSVD);
    endfunction

endpackage

// File: rtl/usr_step_unit.sv
// One-step next-value function of the shift register.
// Pure combinational; LOAD/HOLD/reserved leave the value unchanged.
module usr_step_unit
    import usr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] q,
    input  mode_t        mode,
    input  logic         si_msb,
    input  logic         si_lsb,
    output logic [N-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (mode)
            M_SHR:   q_next = {si_msb, q[N-1:1]};
            M_SHL:   q_next = {q[N-2:0], si_lsb};
            M_ROR:   q_next = {q[0], q[N-1:1]};
            M_ROL:   q_next = {q[N-2:0], q[N-1]};
            M_ASR:   q_next = {q[N-1], q[N-1:1]};
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/usr_burst_shifter.sv
// Multi-mode shift register with a burst sequencer (IDLE/RUN/DONE).
// Define USR_ABORT_EN to add the `abort` input that ends a burst early.
module usr_burst_shifter
    import usr_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic [N-1:0]     d,
    input  logic             si_msb,
    input  logic             si_lsb,
`ifdef USR_ABORT_EN
    input  logic             abort,
`endif
    output logic [N-1:0]     q,
    output logic             so_msb,
    output logic             so_lsb,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [N-1:0]     q_q, q_d;
    logic [N-1:0]     step_q;
    mode_t            cmd_mode;

    assign cmd_mode = mode_t'(mode);

    usr_step_unit #(.N(N)) u_step (
        .q      (q_q),
        .mode   (mode_q),
        .si_msb (si_msb),
        .si_lsb (si_lsb),
        .q_next (step_q)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        q_d     = q_q;
        case (state_q)
            S_RUN: begin
`ifdef USR_ABORT_EN
                // Abort wins over completion and suppresses this edge's step.
                if (abort) begin
                    state_d = S_DONE;
                end else
`endif
                begin
                    q_d   = step_q;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                if (start) begin
                    if (cmd_mode == M_LOAD) begin
                        q_d     = d;
                        state_d = S_DONE;
                    end else if (count == '0 || is_trivial(cmd_mode)) begin
                        state_d = S_DONE;
                    end else begin
                        mode_d  = cmd_mode;
                        rem_d   = count;
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= M_HOLD;
            rem_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
        end
    end

    assign q      = q_q;
    assign so_msb = q_q[N-1];
    assign so_lsb = q_q[0];
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);

endmodule
